decode_stage_nwide: RTL and testbench

//  Parametrised N-wide registered decode stage; successor to the fixed dual-issue decoder.

---
 rtl/decode_stage_nwide.sv | 186 ++++++++++++++++++
 tb/tb_decode_stage_nwide.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_nwide.sv
// rtl/decode_stage_nwide.sv - N-wide registered decode stage with intra-bundle hazard splitting
//
// Purpose: accepts a bundle of ISSUE_WIDTH instructions and decodes each lane into
// op/des/s1/s2/imm. When a lane reads or writes a register that an earlier lane in
// the same beat writes, the bundle is split over several output beats.
//
// Ports:
//   i_clk, i_rst            clock (rising edge), asynchronous active-high reset
//   i_in_valid/o_in_ready   bundle handshake
//   i_in_lane_valid         per-lane occupancy of the offered bundle
//   i_in_instr              lane i at [i*INSTR_W +: INSTR_W]
//   o_out_valid/i_out_ready decoded beat handshake
//   o_out_lane_valid        lanes carried by the current beat
//   o_out_op/des/s1/s2/imm  per-lane decoded fields (zero for lanes not carried)
//   o_out_split             more beats of the same bundle follow this one
module decode_stage_nwide #(
  parameter int ISSUE_WIDTH = 2,
  parameter int INSTR_W     = 32,
  parameter int OP_W        = 4,
  parameter int REG_W       = 4,
  parameter int IMM_W       = 5
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic [ISSUE_WIDTH-1:0]         i_in_lane_valid,
  input  logic [ISSUE_WIDTH*INSTR_W-1:0] i_in_instr,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [ISSUE_WIDTH-1:0]         o_out_lane_valid,
  output logic [ISSUE_WIDTH*OP_W-1:0]    o_out_op,
  output logic [ISSUE_WIDTH*REG_W-1:0]   o_out_des,
  output logic [ISSUE_WIDTH*REG_W-1:0]   o_out_s1,
  output logic [ISSUE_WIDTH*REG_W-1:0]   o_out_s2,
  output logic [ISSUE_WIDTH*IMM_W-1:0]   o_out_imm,
  output logic                           o_out_split
);

  localparam int OP_LO  = INSTR_W - OP_W;
  localparam int DES_LO = OP_LO - REG_W;
  localparam int S1_LO  = DES_LO - REG_W;
  localparam int S2_LO  = S1_LO - REG_W;
  localparam int IMM_LO = S2_LO - IMM_W;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t                         r_state, w_state_nxt;
  logic [ISSUE_WIDTH-1:0]         r_pend_mask, w_pend_nxt;
  logic [ISSUE_WIDTH*INSTR_W-1:0] r_bundle;

  logic                           r_out_valid;
  logic                           r_out_split;
  logic [ISSUE_WIDTH-1:0]         r_out_lane_valid;
  logic [ISSUE_WIDTH*OP_W-1:0]    r_out_op;
  logic [ISSUE_WIDTH*REG_W-1:0]   r_out_des, r_out_s1, r_out_s2;
  logic [ISSUE_WIDTH*IMM_W-1:0]   r_out_imm;

  logic                           w_load, w_accept, w_hit, w_stop, w_unused;
  logic [ISSUE_WIDTH*INSTR_W-1:0] w_src_instr;
  logic [ISSUE_WIDTH-1:0]         w_src_mask, w_sel, w_remain;
  logic [OP_W-1:0]                w_op  [ISSUE_WIDTH];
  logic [REG_W-1:0]               w_des [ISSUE_WIDTH];
  logic [REG_W-1:0]               w_s1  [ISSUE_WIDTH];
  logic [REG_W-1:0]               w_s2  [ISSUE_WIDTH];
  logic [IMM_W-1:0]               w_imm [ISSUE_WIDTH];

  // Output register may take a new beat when it is empty or being drained.
  assign w_load     = !r_out_valid || i_out_ready;
  assign o_in_ready = !i_rst && (r_state == ST_IDLE) && w_load;
  assign w_accept   = i_in_valid && o_in_ready;

  // Bypass: while idle, the incoming bundle is decoded in the same cycle it is
  // accepted so hazard-free bundles stream at one per cycle.
  assign w_src_instr = (r_state == ST_IDLE) ? i_in_instr : r_bundle;
  assign w_src_mask  = (r_state == ST_IDLE) ? (w_accept ? i_in_lane_valid : '0)
                                            : (w_load ? r_pend_mask : '0);
  assign w_unused    = ^w_src_instr;

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      w_op[i]  = w_src_instr[i*INSTR_W + OP_LO  +: OP_W];
      w_des[i] = w_src_instr[i*INSTR_W + DES_LO +: REG_W];
      w_s1[i]  = w_src_instr[i*INSTR_W + S1_LO  +: REG_W];
      w_s2[i]  = w_src_instr[i*INSTR_W + S2_LO  +: REG_W];
      w_imm[i] = w_src_instr[i*INSTR_W + IMM_LO +: IMM_W];
    end
  end

  // Greedy beat selection: lowest pending lane always goes; each later pending
  // lane joins unless one of its registers matches a des already selected.
  // The first conflict ends the beat, so lanes stay in program order.
  always_comb begin
    w_sel  = '0;
    w_stop = 1'b0;
    w_hit  = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      w_hit = 1'b0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (k < i && w_sel[k] &&
            (w_des[k] == w_des[i] || w_des[k] == w_s1[i] || w_des[k] == w_s2[i])) begin
          w_hit = 1'b1;
        end
      end
      if (w_src_mask[i] && !w_stop) begin
        if (w_hit) begin
          w_stop = 1'b1;
        end else begin
          w_sel[i] = 1'b1;
        end
      end
    end
  end

  assign w_remain = w_src_mask & ~w_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_mask;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (w_remain != '0)) begin
          w_state_nxt = ST_HOLD;
          w_pend_nxt  = w_remain;
        end
      end
      ST_HOLD: begin
        if (w_load) begin
          w_pend_nxt = w_remain;
          if (w_remain == '0) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_pend_mask <= '0;
      r_bundle    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_mask <= w_pend_nxt;
      if (w_accept) begin
        r_bundle <= i_in_instr;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid      <= 1'b0;
      r_out_split      <= 1'b0;
      r_out_lane_valid <= '0;
      r_out_op         <= '0;
      r_out_des        <= '0;
      r_out_s1         <= '0;
      r_out_s2         <= '0;
      r_out_imm        <= '0;
    end else if (w_load) begin
      r_out_valid      <= (w_sel != '0);
      r_out_split      <= (w_remain != '0);
      r_out_lane_valid <= w_sel;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        r_out_op[i*OP_W +: OP_W]    <= w_sel[i] ? w_op[i]  : '0;
        r_out_des[i*REG_W +: REG_W] <= w_sel[i] ? w_des[i] : '0;
        r_out_s1[i*REG_W +: REG_W]  <= w_sel[i] ? w_s1[i]  : '0;
        r_out_s2[i*REG_W +: REG_W]  <= w_sel[i] ? w_s2[i]  : '0;
        r_out_imm[i*IMM_W +: IMM_W] <= w_sel[i] ? w_imm[i] : '0;
      end
    end
  end

  assign o_out_valid      = r_out_valid;
  assign o_out_split      = r_out_split;
  assign o_out_lane_valid = r_out_lane_valid;
  assign o_out_op         = r_out_op;
  assign o_out_des        = r_out_des;
  assign o_out_s1         = r_out_s1;
  assign o_out_s2         = r_out_s2;
  assign o_out_imm        = r_out_imm;

endmodule

// File: tb/tb_decode_stage_nwide.sv
// tb/tb_decode_stage_nwide.sv - scoreboard bench for decode_stage_nwide
module tb_decode_stage_nwide;
  localparam int IW      = 2;
  localparam int INSTR_W = 32;
  localparam int OP_W    = 4;
  localparam int REG_W   = 4;
  localparam int IMM_W   = 5;
  localparam int BW      = IW + IW*(OP_W + 3*REG_W + IMM_W) + 1;
  typedef logic [BW-1:0] beat_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [IW-1:0]           in_lane_valid = '0;
  logic [IW*INSTR_W-1:0]   in_instr = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [IW-1:0]           out_lane_valid;
  logic [IW*OP_W-1:0]      out_op;
  logic [IW*REG_W-1:0]     out_des, out_s1, out_s2;
  logic [IW*IMM_W-1:0]     out_imm;
  logic                    out_split;

  decode_stage_nwide #(.ISSUE_WIDTH(IW), .INSTR_W(INSTR_W), .OP_W(OP_W),
                       .REG_W(REG_W), .IMM_W(IMM_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_lane_valid(in_lane_valid), .i_in_instr(in_instr),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_lane_valid(out_lane_valid), .o_out_op(out_op), .o_out_des(out_des),
    .o_out_s1(out_s1), .o_out_s2(out_s2), .o_out_imm(out_imm), .o_out_split(out_split)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t exp_q[$];
  int    rdy_mode = 1;
  beat_t got;
  beat_t snap;
  bit    stalled = 1'b0;

  assign got = {out_lane_valid, out_op, out_des, out_s1, out_s2, out_imm, out_split};

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Reference: split a bundle into beats straight from the lane rules.
  function automatic void model(input logic [IW-1:0] m, input logic [IW*INSTR_W-1:0] ins);
    logic [IW-1:0]       pend, lv;
    logic [IW*OP_W-1:0]  opv;
    logic [IW*REG_W-1:0] dv, av, bv;
    logic [IW*IMM_W-1:0] iv;
    logic [REG_W-1:0]    written[$];
    logic [INSTR_W-1:0]  w;
    logic                stop, clash;
    pend = m;
    while (pend != '0) begin
      lv = '0; opv = '0; dv = '0; av = '0; bv = '0; iv = '0;
      written.delete();
      stop = 1'b0;
      for (int j = 0; j < IW; j++) begin
        if (pend[j] && !stop) begin
          w = ins[j*INSTR_W +: INSTR_W];
          clash = 1'b0;
          foreach (written[q]) begin
            if (written[q] == w[27:24] || written[q] == w[23:20] || written[q] == w[19:16])
              clash = 1'b1;
          end
          if (clash) begin
            stop = 1'b1;
          end else begin
            lv[j] = 1'b1;
            opv[j*OP_W +: OP_W]   = w[31:28];
            dv[j*REG_W +: REG_W]  = w[27:24];
            av[j*REG_W +: REG_W]  = w[23:20];
            bv[j*REG_W +: REG_W]  = w[19:16];
            iv[j*IMM_W +: IMM_W]  = w[15:11];
            written.push_back(w[27:24]);
          end
        end
      end
      pend = pend & ~lv;
      exp_q.push_back({lv, opv, dv, av, bv, iv, (pend != '0)});
    end
  endfunction

  // Monitor: pops one expected beat per output handshake; checks hold-stability under stall.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        n_checks++;
        if ({out_valid, got} !== {1'b1, snap}) begin
          n_errors++;
          $display("FAIL hold_stable got=%h exp=%h", {out_valid, got}, {1'b1, snap});
        end
      end
      if (out_valid && !out_ready) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL in_ready_stall got=%b exp=0", in_ready);
        end
        stalled = 1'b1;
        snap    = got;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_beat got=%h exp=none", got);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (got !== e) begin
            n_errors++;
            $display("FAIL beat got=%h exp=%h", got, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] g, input logic [63:0] e);
    n_checks++;
    if (g !== e) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, g, e);
    end
  endtask

  task automatic send(input logic [IW-1:0] m, input logic [IW*INSTR_W-1:0] ins);
    int t;
    t = 0;
    in_valid = 1'b1; in_lane_valid = m; in_instr = ins;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout got=in_ready_low exp=accept");
      in_valid = 1'b0;
    end else begin
      model(m, ins);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  function automatic logic [INSTR_W-1:0] rnd_instr();
    return {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 5'($urandom), 11'($urandom)};
  endfunction

  initial begin
    time t0;
    int  t;
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_fields", 64'(got), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;

    // Plain decode, both lanes
    send(2'b11, {32'h5678_0800, 32'h1234_F800});
    chk("dec_valid", 64'(out_valid), 1);
    chk("dec_lanes", 64'(out_lane_valid), 64'h3);
    chk("dec_op", 64'(out_op), 64'h51);
    chk("dec_des", 64'(out_des), 64'h62);
    chk("dec_s1", 64'(out_s1), 64'h73);
    chk("dec_s2", 64'(out_s2), 64'h84);
    chk("dec_imm", 64'(out_imm), 64'h03F);
    chk("dec_split", 64'(out_split), 0);

    // RAW split
    send(2'b11, {32'h3521_0000, 32'h1234_0000});
    chk("raw_b1_lanes", 64'(out_lane_valid), 64'h1);
    chk("raw_b1_split", 64'(out_split), 1);
    chk("raw_in_ready", 64'(in_ready), 0);
    @(posedge clk); #1;
    chk("raw_b2_lanes", 64'(out_lane_valid), 64'h2);
    chk("raw_b2_op", 64'(out_op), 64'h30);
    chk("raw_b2_s1", 64'(out_s1), 64'h20);
    chk("raw_b2_split", 64'(out_split), 0);

    // WAW split
    send(2'b11, {32'h2200_0000, 32'h1200_0000});
    chk("waw_b1_lanes", 64'(out_lane_valid), 64'h1);
    chk("waw_b1_split", 64'(out_split), 1);
    @(posedge clk); #1;
    chk("waw_b2_lanes", 64'(out_lane_valid), 64'h2);

    // Partial and empty bundles
    send(2'b10, {32'h5678_0800, 32'h1234_F800});
    chk("partial_lanes", 64'(out_lane_valid), 64'h2);
    chk("partial_split", 64'(out_split), 0);
    send(2'b00, {32'h5678_0800, 32'h1234_F800});
    chk("empty_no_valid", 64'(out_valid), 0);

    // Hazard-free bundles stream one per cycle
    send(2'b11, {32'h5678_0000, 32'h1234_0000});
    t0 = $time;
    for (int i = 0; i < 4; i++) send(2'b11, {32'h5678_0000, 32'h1234_0000});
    chk("stream_cycles", 64'(($time - t0) / 10), 4);

    // Backpressure during a stream
    fork
      begin
        for (int i = 0; i < 8; i++) send(IW'($urandom_range(1, 3)), {rnd_instr(), rnd_instr()});
      end
      begin
        repeat (3) @(posedge clk);
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        rdy_mode = 1;
      end
    join

    // Reset in the middle of a split bundle
    repeat (3) @(posedge clk);
    rdy_mode = 0;
    @(posedge clk); #2;
    send(2'b11, {32'h3521_0000, 32'h1234_0000});
    chk("mid_split_held", 64'(out_split), 1);
    rst = 1'b1;
    #1;
    chk("async_clear", 64'(out_valid), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_in_ready", 64'(in_ready), 0);
    chk("midrst_fields", 64'(got), 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_ready", 64'(in_ready), 1);
    rdy_mode = 1;
    @(posedge clk); #1;
    send(2'b11, {32'h5678_0800, 32'h1234_F800});

    // Randomized traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) send(IW'($urandom_range(0, 3)), {rnd_instr(), rnd_instr()});
    rdy_mode = 1;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 50) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_queue_empty", 64'(exp_q.size()), 0);
    chk("drain_out_idle", 64'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
